// File: rtl/logip_pkg.sv
// Shared definitions for the logic-analyzer IP blocks: divider width and the
// playback FSM state encoding.
package logip_pkg;

  localparam int DIVW_DEFAULT = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } play_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, synchronous flush and no
// fall-through: a word written this cycle becomes visible at the head next cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Flush overrides any push/pop in the same cycle; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    push_ok  = push_i && !full_o && !flush_i;
    pop_ok   = pop_i && !empty_o && !flush_i;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PTRW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pattern_player.sv
// Pattern-generator output stage: buffers sample words and replays them on the
// channel outputs at f_clk/(div+1), pulsing stb_o on every update.
module pattern_player
  import logip_pkg::*;
#(
  parameter int CHLS  = 32,
  parameter int DEPTH = 4,
  parameter int DIVW  = DIVW_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [DIVW-1:0] fdiv_i,
  input  logic            set_div_i,
  input  logic [CHLS-1:0] smpls_i,
  input  logic            vld_i,
  output logic            rdy_o,
  input  logic            start_i,
  input  logic            stop_i,
  output logic [CHLS-1:0] data_o,
  output logic            stb_o,
  output logic            busy_o,
  output logic            underrun_o
);

  localparam int CNTW = $clog2(DEPTH) + 1;

  play_state_e     state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [CHLS-1:0] data_q, data_d;
  logic            stb_q, stb_d;
  logic            underrun_q, underrun_d;

  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CHLS-1:0] fifo_head;
  logic [CNTW-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (CHLS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (stop_i),
    .push_i  (vld_i),
    .wdata_i (smpls_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rdy_o      = !fifo_full;
  assign data_o     = data_q;
  assign stb_o      = stb_q;
  assign busy_o     = (state_q == ST_RUN);
  assign underrun_o = underrun_q;

  // A divider reload (set_div_i) or a stop both suppress the tick of this cycle.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    stb_d      = 1'b0;
    underrun_d = underrun_q;
    fifo_pop   = 1'b0;
    if (set_div_i) begin
      div_d = fdiv_i;
      cnt_d = fdiv_i;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          state_d    = ST_RUN;
          cnt_d      = set_div_i ? fdiv_i : div_q;
          underrun_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (!set_div_i) begin
          if (cnt_q == '0) begin
            cnt_d = div_q;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              data_d   = fifo_head;
              stb_d    = 1'b1;
            end else begin
              underrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - DIVW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      stb_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      stb_q      <= stb_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (fifo_count <= CNTW'(DEPTH))
        else $error("fifo count out of range");
    end
  end

endmodule

// File: doc/pattern_player.md
# pattern_player

Output-direction counterpart to the sampler: accepts CHLS-wide sample words over a valid/ready stream, buffers them in a small FIFO, and drives them onto the channel outputs at the divided sample rate, with a one-cycle strobe per update. It sits between the sample memory readout and the I/O pads when the analyzer runs in pattern-generator mode. The sampler and the player share the divider register semantics, so one configured rate captures and replays identically.

## Interface
- CHLS, 32, number of channels (sample word width)
- DEPTH, 4, FIFO depth in words; power of two, ≥2
- DIVW, 24, divider width (SUMP divider field)
- clk_i  in  1  system clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- fdiv_i  in  DIVW  divider value; output rate = f_clk/(fdiv+1)
- set_div_i  in  1  latch fdiv_i into divider register (one-cycle pulse)
- smpls_i  in  CHLS  sample word to play
- vld_i  in  1  smpls_i valid
- rdy_o  out  1  FIFO can accept; transfer when vld_i & rdy_o
- start_i  in  1  begin playback (pulse)
- stop_i  in  1  end playback and flush FIFO (pulse)
- data_o  out  CHLS  registered channel outputs
- stb_o  out  1  one-cycle pulse, data_o updated this cycle
- busy_o  out  1  high in RUN
- underrun_o  out  1  sticky: tick occurred with FIFO empty

## Operation
- FSM: IDLE, RUN. IDLE --start_i--> RUN; RUN --stop_i--> IDLE. stop_i and start_i in same cycle: stop wins, state → IDLE.
- start_i in RUN: ignored. stop_i in IDLE: flushes FIFO only.
- Divider: register div (reset 0) loaded by set_div_i. Counter cnt loaded with div on start_i (from IDLE) and on set_div_i; in RUN, cnt==0 → tick, cnt ← div; else cnt ← cnt−1. set_div_i and a tick in the same cycle: reload wins, no tick.
- Tick with FIFO non-empty: pop head, data_o ← head, stb_o ← 1.
- Tick with FIFO empty: data_o holds, stb_o ← 0, underrun_o ← 1; stays RUN.
- underrun_o cleared by start_i (accepted from IDLE) or reset only.
- FIFO push whenever vld_i & rdy_o, in either state; rdy_o = !full (combinational from FIFO count).
- No fall-through: word pushed in cycle n can pop no earlier than a tick in cycle n+1. Push and pop in the same cycle on a non-full FIFO are both performed, count unchanged.
- stop_i: FIFO emptied (count, pointers → 0) on that edge; a push in the same cycle is discarded. data_o holds last value in IDLE.
- Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.

## Timing
- Reset values: data_o=0, stb_o=0, busy_o=0, underrun_o=0, rdy_o=1 (FIFO empty), div=0, cnt=0, state IDLE.
- Reset has priority over all inputs, including mid-playback; FIFO contents discarded.
- start_i sampled at edge E0: busy_o high after E0, cnt=div. First tick in cycle div after E0; data_o/stb_o visible after the following edge, i.e. first strobe fdiv+1 cycles after the start edge and every fdiv+1 cycles thereafter.
- fdiv=0: tick every RUN cycle; sustained 1 word/cycle when vld_i held high and FIFO non-empty.
- stb_o never high for more than one consecutive cycle unless fdiv=0.
- busy_o low on the edge after stop_i is sampled; no strobe from a tick in the stop_i cycle.

## Structure
- Shared package logip_pkg: DIVW default constant, typedef for the play FSM enum (IDLE, RUN).
- Sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count, synchronous flush, no fall-through) instantiated once; control and divider in the top module.
- Sub-module reusable by the later readout path.

## Test plan
- Reset mid-RUN with 3 words queued → next cycle data_o=0, stb_o=0, busy_o=0, rdy_o=1, underrun_o=0.
- set_div fdiv=2, push 0xA5A5_0001..0004, start → strobes at 3, 6, 9, 12 cycles after the start edge with those words in order; no underrun.
- fdiv=0, continuous vld_i stream of incrementing words → stb_o high every cycle after the first word, data_o increments by 1, rdy_o never low.
- fdiv=1, push one word 0x0000_00FF, start → one strobe with 0xFF, next tick sets underrun_o=1, data_o stays 0xFF; restart with start_i clears underrun_o.
- Fill FIFO to DEPTH in IDLE → rdy_o=0; extra vld_i word not accepted; stop_i → count 0, rdy_o=1, pushes in stop cycle dropped.
- start_i and stop_i in same cycle from RUN → IDLE; set_div_i coinciding with a tick → no strobe that cycle, next strobe fdiv_new+1 cycles later.
